// File: rtl/pipe_ctrl.sv
// pipe_ctrl: central pipeline controller for the 5-stage core.
// Merges per-stage stall requests into the stall vector, sequences
// exception/eret redirection (defer while MEM waits, freeze one cycle,
// flush one cycle with the new fetch address) and keeps a saturating
// stalled-cycle counter.
module pipe_ctrl #(
    parameter logic [31:0] EXC_VECTOR = 32'h00000040,
    parameter int          CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallreq_if,
    input  logic             stallreq_id,
    input  logic             stallreq_ex,
    input  logic             stallreq_mem,
    input  logic             exc_valid_i,
    input  logic [4:0]       exc_type_i,
    input  logic [31:0]      exc_epc_i,
    input  logic             cnt_clr_i,
    output logic [5:0]       stall,
    output logic             flush,
    output logic [31:0]      new_pc,
    output logic [CNT_W-1:0] stall_cnt
);

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_PEND   = 2'd1,
        ST_FREEZE = 2'd2,
        ST_FLUSH  = 2'd3
    } state_t;

    localparam logic [4:0]       EXC_ERET = 5'h0e;
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    logic [4:0]       type_q, type_d;
    logic [31:0]      epc_q, epc_d;
    logic [31:0]      new_pc_q, new_pc_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [5:0]       base_stall_s;
    logic [5:0]       stall_s;

    // Base stall vector from stage requests; the oldest stalling stage wins.
    always_comb begin
        if (stallreq_mem) begin
            base_stall_s = 6'b011111;
        end else if (stallreq_ex) begin
            base_stall_s = 6'b001111;
        end else if (stallreq_id) begin
            base_stall_s = 6'b000111;
        end else if (stallreq_if) begin
            base_stall_s = 6'b000011;
        end else begin
            base_stall_s = 6'b000000;
        end
    end

    // Redirect FSM next-state, exception latch and stall vector selection.
    always_comb begin
        state_d  = state_q;
        type_d   = type_q;
        epc_d    = epc_q;
        new_pc_d = new_pc_q;
        stall_s  = base_stall_s;
        case (state_q)
            ST_RUN: begin
                if (exc_valid_i) begin
                    type_d  = exc_type_i;
                    epc_d   = exc_epc_i;
                    state_d = stallreq_mem ? ST_PEND : ST_FREEZE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_PEND: begin
                // The first latched exception holds; new requests are dropped.
                if (!stallreq_mem) begin
                    state_d = ST_FREEZE;
                end else begin
                    state_d = ST_PEND;
                end
            end
            ST_FREEZE: begin
                stall_s = 6'b111111;
                state_d = ST_FLUSH;
                // Load the redirect target now so it is a flop output in FLUSH.
                if (type_q == EXC_ERET) begin
                    new_pc_d = epc_q;
                end else begin
                    new_pc_d = EXC_VECTOR;
                end
            end
            ST_FLUSH: begin
                stall_s = 6'b000000;
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
        // Nothing is held while reset is asserted.
        if (rst) begin
            stall_s = 6'b000000;
        end else begin
            stall_s = stall_s;
        end
    end

    // Stalled-cycle counter: clear beats increment, saturates at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (cnt_clr_i) begin
            stall_cnt_d = {CNT_W{1'b0}};
        end else if (stall_s[0] && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_ONE;
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // State, latch and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            type_q      <= 5'h00;
            epc_q       <= 32'h00000000;
            new_pc_q    <= 32'h00000000;
            stall_cnt_q <= {CNT_W{1'b0}};
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            epc_q       <= epc_d;
            new_pc_q    <= new_pc_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall     = stall_s;
    assign flush     = (state_q == ST_FLUSH);
    assign new_pc    = new_pc_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl. Each cycle a test pushes the expected
// {stall, flush, new_pc} into a queue while driving stimulus; the observed
// outputs are queued at the falling edge and each test drains both queues.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_if, stallreq_id, stallreq_ex, stallreq_mem;
    logic        exc_valid_i;
    logic [4:0]  exc_type_i;
    logic [31:0] exc_epc_i;
    logic        cnt_clr_i;
    logic [5:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [3:0]  stall_cnt;

    logic [38:0] exp_q[$];
    logic [38:0] obs_q[$];
    logic [3:0]  obs_cnt;
    int          tests_run;
    int          fails;

    pipe_ctrl #(.EXC_VECTOR(32'h00000040), .CNT_W(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .exc_valid_i  (exc_valid_i),
        .exc_type_i   (exc_type_i),
        .exc_epc_i    (exc_epc_i),
        .cnt_clr_i    (cnt_clr_i),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_cnt    (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One clock cycle: drive inputs, push expectation, sample at negedge.
    // sr = {mem, ex, id, if}
    task automatic cyc(input logic r, input logic c, input logic [3:0] sr,
                       input logic ev, input logic [4:0] et, input logic [31:0] ep,
                       input logic chk, input logic [5:0] es, input logic ef,
                       input logic [31:0] epc_exp);
        rst          = r;
        cnt_clr_i    = c;
        stallreq_if  = sr[0];
        stallreq_id  = sr[1];
        stallreq_ex  = sr[2];
        stallreq_mem = sr[3];
        exc_valid_i  = ev;
        exc_type_i   = et;
        exc_epc_i    = ep;
        if (chk) exp_q.push_back({es, ef, epc_exp});
        @(negedge clk);
        if (chk) obs_q.push_back({stall, flush, new_pc});
        obs_cnt = stall_cnt;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [38:0] e, o;
        cyc(1'b1, 1'b0, 4'b1111, 1'b1, 5'h0c, 32'h1, 1'b1, 6'h00, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 4'b1111, 1'b1, 5'h0c, 32'h1, 1'b1, 6'h00, 1'b0, 32'h0);
        tests_run++;
        if (obs_cnt !== 4'h0) begin
            fails++;
            $display("FAIL reset_cnt: got %h expected %h", obs_cnt, 4'h0);
        end
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b1, 6'h00, 1'b0, 32'h0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin
                fails++;
                $display("FAIL reset[%0d]: got stall=%b flush=%b pc=%h expected stall=%b flush=%b pc=%h",
                         i, o[38:33], o[32], o[31:0], e[38:33], e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_stall_priority();
        logic [38:0] e, o;
        cyc(1'b0, 1'b0, 4'b0101, 1'b0, 5'h00, 32'h0, 1'b1, 6'b001111, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 4'b0001, 1'b0, 5'h00, 32'h0, 1'b1, 6'b000011, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b1, 6'b000000, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 4'b1111, 1'b0, 5'h00, 32'h0, 1'b1, 6'b011111, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 4'b0011, 1'b0, 5'h00, 32'h0, 1'b1, 6'b000111, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 4'b0110, 1'b0, 5'h00, 32'h0, 1'b1, 6'b001111, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b1, 6'b000000, 1'b0, 32'h0);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin
                fails++;
                $display("FAIL stall_prio[%0d]: got stall=%b flush=%b pc=%h expected stall=%b flush=%b pc=%h",
                         i, o[38:33], o[32], o[31:0], e[38:33], e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_immediate_exc();
        logic [38:0] e, o;
        cyc(1'b0, 1'b0, 4'b0000, 1'b1, 5'h0c, 32'h0000_0abc, 1'b1, 6'b000000, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b1, 6'b111111, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b1, 6'b000000, 1'b1, 32'h0000_0040);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b1, 6'b000000, 1'b0, 32'h0000_0040);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin
                fails++;
                $display("FAIL imm_exc[%0d]: got stall=%b flush=%b pc=%h expected stall=%b flush=%b pc=%h",
                         i, o[38:33], o[32], o[31:0], e[38:33], e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_eret_deferred();
        logic [38:0] e, o;
        cyc(1'b0, 1'b0, 4'b1000, 1'b1, 5'h0e, 32'h0000_1234, 1'b1, 6'b011111, 1'b0, 32'h40);
        cyc(1'b0, 1'b0, 4'b1000, 1'b1, 5'h08, 32'h0000_5678, 1'b1, 6'b011111, 1'b0, 32'h40);
        cyc(1'b0, 1'b0, 4'b1000, 1'b0, 5'h00, 32'h0, 1'b1, 6'b011111, 1'b0, 32'h40);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b1, 6'b000000, 1'b0, 32'h40);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b1, 6'b111111, 1'b0, 32'h40);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b1, 6'b000000, 1'b1, 32'h0000_1234);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b1, 6'b000000, 1'b0, 32'h0000_1234);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin
                fails++;
                $display("FAIL eret_pend[%0d]: got stall=%b flush=%b pc=%h expected stall=%b flush=%b pc=%h",
                         i, o[38:33], o[32], o[31:0], e[38:33], e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_flush_ignores_inputs();
        logic [38:0] e, o;
        cyc(1'b0, 1'b0, 4'b0000, 1'b1, 5'h0c, 32'h0, 1'b1, 6'b000000, 1'b0, 32'h1234);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b1, 6'b111111, 1'b0, 32'h1234);
        cyc(1'b0, 1'b0, 4'b1111, 1'b1, 5'h0e, 32'h0000_9999, 1'b1, 6'b000000, 1'b1, 32'h40);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b1, 6'b000000, 1'b0, 32'h40);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b1, 6'b000000, 1'b0, 32'h40);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b1, 6'b000000, 1'b0, 32'h40);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin
                fails++;
                $display("FAIL flush_ign[%0d]: got stall=%b flush=%b pc=%h expected stall=%b flush=%b pc=%h",
                         i, o[38:33], o[32], o[31:0], e[38:33], e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_reset_mid_pend();
        logic [38:0] e, o;
        cyc(1'b0, 1'b0, 4'b1000, 1'b1, 5'h0c, 32'h0, 1'b1, 6'b011111, 1'b0, 32'h40);
        cyc(1'b1, 1'b0, 4'b1000, 1'b0, 5'h00, 32'h0, 1'b0, 6'b000000, 1'b0, 32'h0);
        cyc(1'b1, 1'b0, 4'b1000, 1'b0, 5'h00, 32'h0, 1'b1, 6'b000000, 1'b0, 32'h0);
        tests_run++;
        if (obs_cnt !== 4'h0) begin
            fails++;
            $display("FAIL rst_pend_cnt: got %h expected %h", obs_cnt, 4'h0);
        end
        for (int k = 0; k < 4; k++) begin
            cyc(1'b0, 1'b0, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b1, 6'b000000, 1'b0, 32'h0);
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin
                fails++;
                $display("FAIL rst_pend[%0d]: got stall=%b flush=%b pc=%h expected stall=%b flush=%b pc=%h",
                         i, o[38:33], o[32], o[31:0], e[38:33], e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_counter();
        logic [38:0] e, o;
        logic [3:0]  ec;
        cyc(1'b0, 1'b1, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b1, 6'b000000, 1'b0, 32'h0);
        for (int k = 0; k < 20; k++) begin
            cyc(1'b0, 1'b0, 4'b0001, 1'b0, 5'h00, 32'h0, 1'b1, 6'b000011, 1'b0, 32'h0);
            ec = (k > 15) ? 4'hF : 4'(k);
            tests_run++;
            if (obs_cnt !== ec) begin
                fails++;
                $display("FAIL cnt_sat[%0d]: got %h expected %h", k, obs_cnt, ec);
            end
        end
        // Clear while still stalling: clear wins, then counting resumes.
        cyc(1'b0, 1'b1, 4'b0001, 1'b0, 5'h00, 32'h0, 1'b1, 6'b000011, 1'b0, 32'h0);
        for (int k = 0; k < 3; k++) begin
            cyc(1'b0, 1'b0, 4'b0001, 1'b0, 5'h00, 32'h0, 1'b1, 6'b000011, 1'b0, 32'h0);
            tests_run++;
            if (obs_cnt !== 4'(k)) begin
                fails++;
                $display("FAIL cnt_clr[%0d]: got %h expected %h", k, obs_cnt, 4'(k));
            end
        end
        // The FREEZE cycle counts as a stalled cycle.
        cyc(1'b0, 1'b1, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b1, 6'b000000, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 4'b0000, 1'b1, 5'h03, 32'h0, 1'b1, 6'b000000, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b1, 6'b111111, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b1, 6'b000000, 1'b1, 32'h40);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b1, 6'b000000, 1'b0, 32'h40);
        tests_run++;
        if (obs_cnt !== 4'h1) begin
            fails++;
            $display("FAIL cnt_freeze: got %h expected %h", obs_cnt, 4'h1);
        end
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin
                fails++;
                $display("FAIL counter[%0d]: got stall=%b flush=%b pc=%h expected stall=%b flush=%b pc=%h",
                         i, o[38:33], o[32], o[31:0], e[38:33], e[32], e[31:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [38:0] e, o;
        cyc(1'b0, 1'b0, 4'b0000, 1'b1, 5'h0c, 32'h0, 1'b1, 6'b000000, 1'b0, 32'h40);
        cyc(1'b0, 1'b0, 4'b0000, 1'b1, 5'h0c, 32'h0, 1'b1, 6'b111111, 1'b0, 32'h40);
        cyc(1'b0, 1'b0, 4'b0000, 1'b1, 5'h0c, 32'h0, 1'b1, 6'b000000, 1'b1, 32'h40);
        cyc(1'b0, 1'b0, 4'b0000, 1'b1, 5'h0e, 32'h0000_abcd, 1'b1, 6'b000000, 1'b0, 32'h40);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b1, 6'b111111, 1'b0, 32'h40);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b1, 6'b000000, 1'b1, 32'h0000_abcd);
        cyc(1'b0, 1'b0, 4'b0000, 1'b0, 5'h00, 32'h0, 1'b1, 6'b000000, 1'b0, 32'h0000_abcd);
        for (int i = 0; exp_q.size() > 0; i++) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); tests_run++;
            if (o !== e) begin
                fails++;
                $display("FAIL b2b[%0d]: got stall=%b flush=%b pc=%h expected stall=%b flush=%b pc=%h",
                         i, o[38:33], o[32], o[31:0], e[38:33], e[32], e[31:0]);
            end
        end
    endtask

    // Test sequence.
    initial begin
        tests_run    = 0;
        fails        = 0;
        obs_cnt      = 4'h0;
        rst          = 1'b1;
        cnt_clr_i    = 1'b0;
        stallreq_if  = 1'b0;
        stallreq_id  = 1'b0;
        stallreq_ex  = 1'b0;
        stallreq_mem = 1'b0;
        exc_valid_i  = 1'b0;
        exc_type_i   = 5'h00;
        exc_epc_i    = 32'h0;
        test_reset();
        test_stall_priority();
        test_immediate_exc();
        test_eret_deferred();
        test_flush_ignores_inputs();
        test_reset_mid_pend();
        test_counter();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Central pipeline controller for the 5-stage core. It merges per-stage stall requests into the 6-bit stall vector consumed by the pc, if_id, id_ex, ex_mem and mem_wb registers. It also sequences exception/eret redirection: it defers the redirect while a memory access is in flight, freezes the pipe for one cycle, then issues a one-cycle flush with the new fetch address. It keeps a saturating stalled-cycle counter for performance monitoring.

Parameters:
EXC_VECTOR, 32'h00000040, fetch address for every exception type except eret
CNT_W, 32, width of stall cycle counter

Ports:
clk  in  1  clock
rst  in  1  reset
stallreq_if  in  1  fetch bus wait
stallreq_id  in  1  load-use hazard
stallreq_ex  in  1  multi-cycle EX op (div/madd)
stallreq_mem  in  1  data bus wait
exc_valid_i  in  1  MEM stage reports exception or eret (level)
exc_type_i  in  5  exception code; 5'h0e = eret
exc_epc_i  in  32  EPC value from CP0 (used for eret)
cnt_clr_i  in  1  clear stall counter
stall  out  6  bit0 pc, 1 if, 2 id, 3 ex, 4 mem, 5 wb; 1 = Stop
flush  out  1  clear all pipeline registers, load new_pc
new_pc  out  32  redirect address, valid while flush=1
stall_cnt  out  CNT_W  cycles with stall[0]=1, saturating

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. Reset state is RUN. Outputs during and after reset: stall=0, flush=0, new_pc=0, stall_cnt=0, latched type/epc=0. Reset mid-PEND/FREEZE/FLUSH discards the pending redirect.
- Base stall vector, combinational, priority mem>ex>id>if:
  - mem: 6'b011111
  - ex: 6'b001111
  - id: 6'b000111
  - if: 6'b000011
  - none: 6'b000000
  - wb never stalls in base mode.
- FSM states: RUN, PEND, FREEZE, FLUSH.
- RUN:
  - stall = base.
  - exc_valid_i & !stallreq_mem: latch exc_type_i/exc_epc_i, go to FREEZE.
  - exc_valid_i & stallreq_mem: latch, go to PEND.
- PEND:
  - stall = base.
  - exc_valid_i is ignored. The first latch holds.
  - When stallreq_mem=0, go to FREEZE.
- FREEZE (1 cycle):
  - stall = 6'b111111, so nothing retires past MEM.
  - flush=0.
  - Unconditionally go to FLUSH.
- FLUSH (1 cycle):
  - flush=1, stall=6'b000000. All stallreq_* and exc_valid_i are ignored.
  - new_pc = latched epc if latched type==5'h0e, else EXC_VECTOR.
  - Unconditionally go to RUN.
- flush and new_pc are decoded from registered state and latch only. No input-to-flush combinational path.
- new_pc holds its last value outside FLUSH (0 after reset).
- Redirect latency: exception accepted in RUN cycle N → FREEZE at N+1 → flush=1 at N+2 → RUN at N+3.
- Back-to-back exceptions: exc_valid_i held through FLUSH is ignored there. If still high in the RUN cycle after FLUSH, it is accepted again. Sources must deassert on flush.
- stall_cnt:
  - Increments each cycle stall[0]=1, including the FREEZE cycle.
  - Saturates at all-ones, no wrap.
  - cnt_clr_i=1 clears it to 0 next cycle and wins over a simultaneous increment.

Test Plan:
1. Stall priority: stallreq_if=1 and stallreq_ex=1 in the same cycle → stall=6'b001111. Then only stallreq_if=1 → 6'b000011. Then none → 6'b000000, flush=0 throughout.
2. Immediate exception: in RUN, exc_valid_i=1, exc_type_i=5'h0c, stallreq_mem=0 at cycle N → stall=6'b111111 at N+1. At N+2, flush=1, stall=0, new_pc=32'h00000040. At N+3, flush=0, back in RUN.
3. Eret deferred by memory wait:
   - Stimulus: exc_valid_i=1, type=5'h0e, epc=32'h0000_1234 while stallreq_mem=1 for 3 cycles; a second exc_valid_i (type 5'h08, epc 32'h0000_5678) arrives during PEND.
   - Response: stall=6'b011111 for those 3 cycles, then FREEZE, then flush=1 with new_pc=32'h00001234 (second request in PEND ignored).
4. Inputs ignored in FLUSH: stallreq_mem=1 and exc_valid_i=1 asserted only in the FLUSH cycle → stall=0, flush=1, no new PEND/FREEZE afterward.
5. Reset mid-sequence: rst=1 during PEND → next cycle state RUN, stall=0, flush=0, stall_cnt=0, and no flush ever issued for the discarded exception.
6. Counter:
   - With CNT_W=4, hold stallreq_if=1 for 20 cycles → stall_cnt saturates at 4'hF.
   - Assert cnt_clr_i with stall still active → stall_cnt=0 next cycle, then resumes counting 1, 2, ….
